// File: rtl/traffic.sv
// Fixed-time traffic-light controller: one crossing, two car lamps and two walker lamps.
// Optional macro PED_FLASH_EN enables the walker "hurry" indication at the end of each green.
module traffic #(
  parameter int GREEN_CYC  = 20,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_CYC = 2,
  parameter int FLASH_CYC  = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [2:0] h_car_traffic,
  output logic [2:0] h_walker_traffic,
  output logic [2:0] v_car_traffic,
  output logic [2:0] v_walker_traffic
);

  localparam logic [2:0] S_ALLRED_H = 3'd0;
  localparam logic [2:0] S_H_GREEN  = 3'd1;
  localparam logic [2:0] S_H_YELLOW = 3'd2;
  localparam logic [2:0] S_ALLRED_V = 3'd3;
  localparam logic [2:0] S_V_GREEN  = 3'd4;
  localparam logic [2:0] S_V_YELLOW = 3'd5;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam logic [7:0] LEN_GREEN   = 8'(GREEN_CYC);
  localparam logic [7:0] LEN_YELLOW  = 8'(YELLOW_CYC);
  localparam logic [7:0] LEN_ALLRED  = 8'(ALLRED_CYC);
  // With FLASH_CYC=0 this equals GREEN_CYC, which the counter never reaches.
  localparam logic [7:0] HURRY_START = 8'(GREEN_CYC - FLASH_CYC);

`ifdef PED_FLASH_EN
  localparam logic FLASH_ON = 1'b1;
`else
  localparam logic FLASH_ON = 1'b0;
`endif

  logic [2:0] state;
  logic [7:0] cnt;
  logic [7:0] phase_len;
  logic       last;
  logic       hurry;

  function automatic logic [2:0] next_state(input logic [2:0] s);
    case (s)
      S_ALLRED_H: next_state = S_H_GREEN;
      S_H_GREEN:  next_state = S_H_YELLOW;
      S_H_YELLOW: next_state = S_ALLRED_V;
      S_ALLRED_V: next_state = S_V_GREEN;
      S_V_GREEN:  next_state = S_V_YELLOW;
      default:    next_state = S_ALLRED_H;
    endcase
  endfunction

  always_comb begin
    phase_len = 8'd1;
    case (state)
      S_ALLRED_H, S_ALLRED_V: phase_len = LEN_ALLRED;
      S_H_GREEN,  S_V_GREEN:  phase_len = LEN_GREEN;
      S_H_YELLOW, S_V_YELLOW: phase_len = LEN_YELLOW;
      default:                phase_len = 8'd1;
    endcase
  end

  assign last  = (cnt == (phase_len - 8'd1));
  assign hurry = FLASH_ON && (cnt >= HURRY_START);

  // State/counter register: advance on terminal count, recover from illegal encodings.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_ALLRED_H;
      cnt   <= 8'd0;
    end else begin
      case (state)
        S_ALLRED_H, S_H_GREEN, S_H_YELLOW, S_ALLRED_V, S_V_GREEN, S_V_YELLOW: begin
          if (last) begin
            state <= next_state(state);
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= S_ALLRED_H;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

  // Moore decode; every lamp defaults to red so unknown states stay safe.
  always_comb begin
    h_car_traffic    = LAMP_RED;
    h_walker_traffic = LAMP_RED;
    v_car_traffic    = LAMP_RED;
    v_walker_traffic = LAMP_RED;
    case (state)
      S_H_GREEN: begin
        h_car_traffic    = LAMP_GREEN;
        h_walker_traffic = hurry ? LAMP_YELLOW : LAMP_GREEN;
      end
      S_H_YELLOW: h_car_traffic = LAMP_YELLOW;
      S_V_GREEN: begin
        v_car_traffic    = LAMP_GREEN;
        v_walker_traffic = hurry ? LAMP_YELLOW : LAMP_GREEN;
      end
      S_V_YELLOW: v_car_traffic = LAMP_YELLOW;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic.sv
// Directed bench for traffic: default timing over three periods, a minimum-length
// instance (all phases 1 cycle), and a mid-green reset.
module tb_traffic;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] h_car, h_walk, v_car, v_walk;
  logic [2:0] s_h_car, s_h_walk, s_v_car, s_v_walk;

  int ncmp = 0;
  int nerr = 0;

`ifdef PED_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  traffic dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .h_car_traffic    (h_car),
    .h_walker_traffic (h_walk),
    .v_car_traffic    (v_car),
    .v_walker_traffic (v_walk)
  );

  traffic #(.GREEN_CYC(1), .YELLOW_CYC(1), .ALLRED_CYC(1), .FLASH_CYC(1)) dut_s (
    .clk              (clk),
    .reset_n          (reset_n),
    .h_car_traffic    (s_h_car),
    .h_walker_traffic (s_h_walk),
    .v_car_traffic    (s_v_car),
    .v_walker_traffic (s_v_walk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {h_car, h_walk, v_car, v_walk} for default timing, t cycles after reset.
  function automatic logic [11:0] exp_def(input int t);
    int p;
    p = t % 52;
    if (p < 2)       return {R, R, R, R};
    else if (p < 22) return {G, (FLASH && p >= 16) ? Y : G, R, R};
    else if (p < 26) return {Y, R, R, R};
    else if (p < 28) return {R, R, R, R};
    else if (p < 48) return {R, R, G, (FLASH && p >= 42) ? Y : G};
    else             return {R, R, Y, R};
  endfunction

  // Expected outputs for the all-ones instance: period 6.
  function automatic logic [11:0] exp_small(input int t);
    case (t % 6)
      0:       return {R, R, R, R};
      1:       return {G, FLASH ? Y : G, R, R};
      2:       return {Y, R, R, R};
      3:       return {R, R, R, R};
      4:       return {R, R, G, FLASH ? Y : G};
      default: return {R, R, Y, R};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_invariants(input string who, input logic [2:0] hc, input logic [2:0] hw,
                                  input logic [2:0] vc, input logic [2:0] vw);
    chk({who, "_car_excl"}, 12'((hc != R) && (vc != R)), 12'd0);
    chk({who, "_onehot"}, 12'($onehot(hc) && $onehot(hw) && $onehot(vc) && $onehot(vw)), 12'd1);
    chk({who, "_hwalk_rule"}, 12'((hw != R) && (hc != G)), 12'd0);
    chk({who, "_vwalk_rule"}, 12'((vw != R) && (vc != G)), 12'd0);
  endtask

  initial begin
    int t;
    bit saw_hurry;
    saw_hurry = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {h_car, h_walk, v_car, v_walk}, {R, R, R, R});
    chk("reset_state_s", {s_h_car, s_h_walk, s_v_car, s_v_walk}, {R, R, R, R});
    reset_n = 1'b1;

    for (t = 0; t < 156; t++) begin
      if (t > 0) step();
      chk($sformatf("def_t%0d", t), {h_car, h_walk, v_car, v_walk}, exp_def(t));
      chk($sformatf("small_t%0d", t), {s_h_car, s_h_walk, s_v_car, s_v_walk}, exp_small(t));
      check_invariants("def", h_car, h_walk, v_car, v_walk);
      check_invariants("small", s_h_car, s_h_walk, s_v_car, s_v_walk);
      if (h_walk == Y || v_walk == Y) saw_hurry = 1'b1;
    end
    chk("hurry_seen", 12'(saw_hurry), 12'(FLASH));

    // Advance into the middle of horizontal green, then pulse reset for one edge.
    while ((t % 52) != 10) begin
      step();
      t++;
    end
    chk("mid_green_pre", {h_car, h_walk}, {G, G});
    reset_n = 1'b0;
    step();
    chk("mid_reset_red", {h_car, h_walk, v_car, v_walk}, {R, R, R, R});
    chk("mid_reset_red_s", {s_h_car, s_h_walk, s_v_car, s_v_walk}, {R, R, R, R});
    reset_n = 1'b1;
    step();
    chk("post_rel_t1", {h_car, h_walk, v_car, v_walk}, {R, R, R, R});
    chk("post_rel_t1_s", {s_h_car, s_h_walk, s_v_car, s_v_walk}, exp_small(1));
    step();
    chk("post_rel_t2", {h_car, h_walk, v_car, v_walk}, {G, G, R, R});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
